// File: rtl/pu_out_packer_pkg.sv
// Shared constants, FSM state type and the requantization function for the PU
// output packer and any other PU-side consumer of the signed PU sums.
package pu_out_packer_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int SUM_WIDTH   = DATA_WIDTH * 2 + 6;
  localparam int PACK        = 8;
  localparam int ADDR_WIDTH  = 6;
  localparam int SHIFT_WIDTH = 5;
  localparam int LANE_WIDTH  = $clog2(PACK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic                  clipped;
    logic [DATA_WIDTH-1:0] value;
  } requant_t;

  localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_WIDTH:0] WIDE_MAX =
    $signed({{(SUM_WIDTH-DATA_WIDTH+1){1'b0}}, RES_MAX});
  localparam logic signed [SUM_WIDTH:0] WIDE_MIN =
    $signed({{(SUM_WIDTH-DATA_WIDTH+1){1'b1}}, RES_MIN});
  localparam logic [SUM_WIDTH:0] ROUND_ONE = {{SUM_WIDTH{1'b0}}, 1'b1};

  // Round-half-up arithmetic right shift, then clip to the signed DATA_WIDTH range.
  // The extra guard bit keeps sum + half-LSB from wrapping at the positive limit.
  function automatic requant_t requant(input logic [SUM_WIDTH-1:0]   sum,
                                       input logic [SHIFT_WIDTH-1:0] shift);
    logic signed [SUM_WIDTH:0] wide;
    logic        [SUM_WIDTH:0] half;
    requant_t                  res;
    wide = $signed({sum[SUM_WIDTH-1], sum});
    half = '0;
    if (shift != '0) half = ROUND_ONE << (shift - SHIFT_WIDTH'(1));
    wide = (wide + $signed(half)) >>> shift;
    if (wide > WIDE_MAX) begin
      res.clipped = 1'b1;
      res.value   = RES_MAX;
    end else if (wide < WIDE_MIN) begin
      res.clipped = 1'b1;
      res.value   = RES_MIN;
    end else begin
      res.clipped = 1'b0;
      res.value   = wide[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pu_out_packer_requant.sv
// Combinational round/shift/saturate stage with a clip flag; also usable on the
// PU ReLU path.
module pu_requant
  import pu_out_packer_pkg::*;
(
  input  logic [SUM_WIDTH-1:0]   sum,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   clipped
);

  requant_t rq;

  assign rq      = requant(sum, shift);
  assign result  = rq.value;
  assign clipped = rq.clipped;

endmodule

// File: rtl/pu_out_packer.sv
// Requantizes PU sums and packs PACK results per word towards the activation buffer.
// Optional clip counter port sat_count is enabled by defining PU_OUT_SAT_COUNT_EN.
module pu_out_packer
  import pu_out_packer_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_start,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SUM_WIDTH-1:0]        in_sum,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PACK*DATA_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [PACK-1:0]             out_byte_en,
`ifdef PU_OUT_SAT_COUNT_EN
  output logic [15:0]                 sat_count,
`endif
  output logic                        out_done
);

  state_e                      state_q, state_d;
  logic [SHIFT_WIDTH-1:0]      shift_q;
  logic [ADDR_WIDTH-1:0]       addr_ptr;
  logic [LANE_WIDTH-1:0]       lane_cnt;
  logic [PACK*DATA_WIDTH-1:0]  lanes_q, lanes_next;
  logic [PACK-1:0]             be_next;
  logic [DATA_WIDTH-1:0]       rq_value;
  logic                        rq_clipped;
  logic                        accept, handshake, emit, start_ok, done_d;

  pu_requant u_requant (
    .sum     (in_sum),
    .shift   (shift_q),
    .result  (rq_value),
    .clipped (rq_clipped)
  );

  // A new sample is only taken if the output slot is free or drains this cycle.
  assign in_ready  = (state_q == ST_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign emit      = accept && ((lane_cnt == LANE_WIDTH'(PACK - 1)) || in_last);
  assign start_ok  = (state_q == ST_IDLE) && in_start;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    lanes_next = lanes_q;
    lanes_next[lane_cnt*DATA_WIDTH +: DATA_WIDTH] = rq_value;
    be_next = '0;
    for (int i = 0; i < PACK; i++) be_next[i] = (i <= int'(lane_cnt));
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (in_start) state_d = ST_RUN;
      ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (handshake) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the pack register is a handful of flops, not a RAM, so it is reset and
  // also cleared after every emitted word; unused lanes therefore read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      addr_ptr    <= '0;
      lane_cnt    <= '0;
      lanes_q     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_addr    <= '0;
      out_byte_en <= '0;
      out_done    <= 1'b0;
    end else begin
      out_done <= done_d;
      if (start_ok) begin
        shift_q  <= cfg_shift;
        addr_ptr <= cfg_base_addr;
        lane_cnt <= '0;
        lanes_q  <= '0;
      end
      // addr_ptr always names the next word to be emitted.
      if (emit) begin
        out_valid   <= 1'b1;
        out_data    <= lanes_next;
        out_byte_en <= be_next;
        out_addr    <= addr_ptr;
        addr_ptr    <= addr_ptr + ADDR_WIDTH'(1);
        lanes_q     <= '0;
        lane_cnt    <= '0;
      end else begin
        if (handshake) out_valid <= 1'b0;
        if (accept) begin
          lanes_q  <= lanes_next;
          lane_cnt <= lane_cnt + LANE_WIDTH'(1);
        end
      end
    end
  end

`ifdef PU_OUT_SAT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              sat_count <= '0;
    else if (start_ok)                                    sat_count <= '0;
    else if (accept && rq_clipped && (sat_count != '1))   sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: doc/pu_out_packer.md
Name: pu_out_packer

Overview:
- Downstream neighbour of the PU. Consumes the signed partial/total sums the PU emits (out_total_sum, 2*DATA_WIDTH+6 bits).
- Requantizes each sum to DATA_WIDTH with a rounding right shift and saturation.
- Packs PACK results into one wide word and hands it to the activation buffer over a valid/ready interface, with an auto-incrementing write address.
- Controlled per layer by a start pulse and a last-sample flag.

Parameters:
- DATA_WIDTH, 8, width of one requantized result.
- SUM_WIDTH, 22, width of the incoming PU sum (DATA_WIDTH*2+6).
- PACK, 8, results per output word.
- ADDR_WIDTH, 6, output buffer word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_start  in  1  one-cycle pulse; latches cfg_* and starts a layer (IDLE only).
- cfg_shift  in  5  right-shift amount, 0..SUM_WIDTH-1.
- cfg_base_addr  in  ADDR_WIDTH  first output word address.
- in_valid  in  1  in_sum valid.
- in_ready  out  1  block accepts in_sum this cycle.
- in_sum  in  SUM_WIDTH  signed PU result.
- in_last  in  1  qualifies the final sample of the layer.
- out_valid  out  1  out_data/out_addr/out_byte_en valid.
- out_ready  in  1  buffer accepts the word.
- out_data  out  PACK*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_addr  out  ADDR_WIDTH  word address.
- out_byte_en  out  PACK  lane-valid mask.
- out_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: state IDLE; lane count 0; pack register 0; out_valid, out_data, out_addr, out_byte_en, out_done all 0; latched shift/base 0.
- States:
  - IDLE: in_ready=0. in_start -> RUN, latch cfg_shift/cfg_base_addr, addr_ptr = base.
  - RUN: in_ready = !out_valid || out_ready. An accepted in_last -> DRAIN.
  - DRAIN: in_ready=0. Handshake of the final word -> IDLE with out_done=1 for one cycle.
  - in_start outside IDLE is ignored.
- Requant (combinational on accept):
  - s>0: r = (in_sum + (1<<(s-1))) >>> s (arithmetic shift, round half up).
  - s=0: r = in_sum.
  - Compute with one guard bit so the rounding add cannot overflow.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], i.e. [-128, 127].
- Packing: an accepted sample writes lane[lane_cnt] and lane_cnt increments.
- Word emission: when lane_cnt reaches PACK-1 on accept, or on an accepted in_last:
  - Next cycle, out_valid=1, out_data = packed lanes, out_byte_en = ones in lanes 0..lane_cnt.
  - Unused lanes are driven 0.
  - lane_cnt resets to 0.
  - Latency is 1 cycle from the accepting edge to out_valid.
- Output hold: out_valid/out_data/out_addr/out_byte_en stay stable until out_valid && out_ready. On that handshake, addr_ptr increments and wraps modulo 2^ADDR_WIDTH.
- Simultaneous events:
  - A handshake of word k and acceptance of the sample completing word k+1 in the same cycle is legal. Word k+1 appears the following cycle with no bubble.
  - in_last on lane PACK-1 emits exactly one full word (no extra empty word).
- in_valid while in_ready=0 is not consumed; the source holds its data.
- rst mid-layer aborts everything; a word in flight is dropped and out_done is not pulsed.

Optional Feature:
- Macro: PU_OUT_SAT_COUNT_EN.
- With it defined:
  - Adds output port sat_count [15:0], cleared on in_start and on rst.
  - Increments once per accepted sample whose value was clipped, saturating at 16'hFFFF.
- Without it: no port, no counter logic.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and SUM_WIDTH constants.
  - The state enum (IDLE, RUN, DRAIN).
  - A requant function (sum, shift) -> {clipped, DATA_WIDTH result}.
- One natural sub-module, pu_requant: the combinational round/shift/saturate with a clip flag. It is reusable by the PU's ReLU path.

Test Plan:
- Full word: start, shift=4, base=5; feed 8 sums = 16*i+8 for i=0..7 with in_last on the 8th, out_ready=1 -> one word at addr 5, lanes {1,2,…,8}, byte_en 8'hFF, out_done 1 cycle after the handshake.
- Saturation/rounding: shift=2; sums 1000, -1000, 6, -7, 2 -> 127, -128, 2, -2, 1. With PU_OUT_SAT_COUNT_EN, sat_count=2.
- Partial flush: 11 samples with in_last on the 11th -> word 1 byte_en 8'hFF, word 2 byte_en 8'h07 with lanes 3..7 zero, addresses base and base+1.
- Backpressure: hold out_ready=0 for 5 cycles while word 1 is pending -> in_ready low from the cycle word 1 is valid; word stable; no samples lost; a 16-sample layer yields exactly 2 words.
- Address wrap: base=63, 3 full words -> addresses 63, 0, 1.
- Reset mid-layer: assert rst after 3 accepted samples -> all outputs 0 and state IDLE; a subsequent start plus 8 samples produces a clean word with no stale lanes.
